// File: rtl/sm_prog_checker.sv
// Program/answer memory and result scorer for the stack machine.
// Serves instr from pc, scores d_valid results, gives a verdict on fin.
module sm_prog_checker #(
  parameter int DEPTH       = 1024,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic [9:0]  load_addr,
  input  logic [35:0] load_data,
  input  logic        start,
  input  logic [9:0]  pc,
  input  logic        d_valid,
  input  logic [19:0] out_data,
  input  logic [2:0]  err_code,
  input  logic        fin,
  output logic [12:0] instr,
  output logic [22:0] hit_cnt,
  output logic [15:0] err_cnt,
  output logic        done,
  output logic        pass,
  output logic        timeout
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  logic [35:0]   mem [DEPTH];
  state_e        state_q, state_d;
  logic [22:0]   hit_q, hit_d;
  logic [15:0]   err_q, err_d;
  logic          to_q, to_d;
  logic          miss_q, miss_d;
  logic          pass_q, pass_d;
  logic [CW-1:0] cyc_q, cyc_d;

  logic [35:0] ent;
  logic [2:0]  op;
  logic [22:0] exp_hit;
  logic        clr;
  logic        hit_inc;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;
  logic        alu;
  logic        match;

  always_ff @(posedge clk) begin
    if (load_en && state_q != RUN)
      mem[load_addr] <= load_data;
  end

  always_comb begin
    ent = '0;
    if (32'(pc) < DEPTH)
      ent = mem[pc];
  end

  assign instr   = ent[35:23];
  assign op      = ent[35:33];
  assign exp_hit = mem[DEPTH-1][22:0];
  assign alu     = (op == 3'b001) || (op == 3'b010) || (op == 3'b011);
  assign match   = (out_data == ent[19:0]) && (err_code == ent[22:20]);

  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    miss_d  = miss_q;
    pass_d  = pass_q;
    cyc_d   = cyc_q;
    clr     = 1'b0;
    hit_inc = 1'b0;
    err_inc = 2'd0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          clr     = 1'b1;
          to_d    = 1'b0;
          miss_d  = 1'b0;
          pass_d  = 1'b0;
          cyc_d   = '0;
        end
      end
      RUN: begin
        if (fin) begin
          state_d = DONE;
          pass_d  = (err_q == '0) && (hit_q == exp_hit) && !to_q;
        end else begin
          unique case (1'b1)
            (op == 3'b000): begin
              if (d_valid) begin
                if (err_code == ent[22:20]) hit_inc = 1'b1;
                else err_inc = 2'd1;
              end
              // a pending ALU miss is charged when the next PUSH arrives
              if (miss_q) begin
                err_inc = err_inc + 2'd1;
                miss_d  = 1'b0;
              end
            end
            alu: begin
              if (d_valid) begin
                if (match) hit_inc = 1'b1;
                else err_inc = 2'd1;
                miss_d = 1'b0;
              end else begin
                miss_d = 1'b1;
              end
            end
            default: ;
          endcase
          if (cyc_q == CW'(TIMEOUT_CYC - 1)) begin
            state_d = DONE;
            to_d    = 1'b1;
            pass_d  = 1'b0;
          end else begin
            cyc_d = cyc_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    err_sum = {1'b0, err_q} + 17'(err_inc);
    if (clr) begin
      hit_d = '0;
      err_d = '0;
    end else begin
      hit_d = (hit_q == '1) ? hit_q : hit_q + 23'(hit_inc);
      err_d = err_sum[16] ? '1 : err_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hit_q   <= '0;
      err_q   <= '0;
      to_q    <= 1'b0;
      miss_q  <= 1'b0;
      pass_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
      to_q    <= to_d;
      miss_q  <= miss_d;
      pass_q  <= pass_d;
      cyc_q   <= cyc_d;
    end
  end

  assign hit_cnt = hit_q;
  assign err_cnt = err_q;
  assign done    = (state_q == DONE);
  assign pass    = pass_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_sm_prog_checker.sv
// Directed and randomized bench for sm_prog_checker.
// Scores the DUT against a run-level reference model.
module tb_sm_prog_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [35:0] load_data;
  logic        start;
  logic [9:0]  pc;
  logic        d_valid;
  logic [19:0] out_data;
  logic [2:0]  err_code;
  logic        fin;
  logic [12:0] instr;
  logic [22:0] hit_cnt;
  logic [15:0] err_cnt;
  logic        done;
  logic        pass;
  logic        timeout;

  sm_prog_checker #(.DEPTH(1024), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .pc(pc), .d_valid(d_valid),
    .out_data(out_data), .err_code(err_code), .fin(fin),
    .instr(instr), .hit_cnt(hit_cnt), .err_cnt(err_cnt),
    .done(done), .pass(pass), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [35:0] mm [1024];
  logic m_run, m_done, m_pass, m_to, m_miss;
  int   m_hit, m_err, m_cyc;

  task automatic chk(string tag, logic [35:0] obs, logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_pass = 0; m_to = 0; m_miss = 0;
    m_hit = 0; m_err = 0; m_cyc = 0;
  endtask

  task automatic model_step();
    logic [35:0] e;
    logic [2:0]  op;
    e  = mm[pc];
    op = e[35:33];
    if (m_run) begin
      if (fin) begin
        m_run  = 0;
        m_done = 1;
        m_pass = (m_err == 0) && (m_hit == int'(mm[1023][22:0])) && !m_to;
      end else begin
        if (op == 3'd0) begin
          if (d_valid) begin
            if (err_code == e[22:20]) m_hit++;
            else m_err++;
          end
          if (m_miss) begin
            m_err++;
            m_miss = 0;
          end
        end else if (op <= 3'd3) begin
          if (d_valid) begin
            if (out_data == e[19:0] && err_code == e[22:20]) m_hit++;
            else m_err++;
            m_miss = 0;
          end else begin
            m_miss = 1;
          end
        end
        if (m_cyc == 15) begin
          m_run = 0; m_done = 1; m_to = 1; m_pass = 0;
        end else begin
          m_cyc++;
        end
      end
    end else begin
      if (load_en) mm[load_addr] = load_data;
      if (start) begin
        m_run = 1; m_done = 0; m_pass = 0; m_to = 0; m_miss = 0;
        m_hit = 0; m_err = 0; m_cyc = 0;
      end
    end
  endtask

  task automatic compare(string tag);
    chk({tag, "_hit"}, 36'(hit_cnt), 36'(m_hit));
    chk({tag, "_err"}, 36'(err_cnt), 36'(m_err));
    chk({tag, "_done"}, 36'(done), 36'(m_done));
    chk({tag, "_pass"}, 36'(pass), 36'(m_pass));
    chk({tag, "_to"}, 36'(timeout), 36'(m_to));
    if (!$isunknown(mm[pc]))
      chk({tag, "_instr"}, 36'(instr), 36'(mm[pc][35:23]));
  endtask

  task automatic cyc(string tag);
    model_step();
    @(posedge clk);
    #1;
    start   = 0;
    load_en = 0;
    compare(tag);
  endtask

  task automatic load(logic [9:0] a, logic [35:0] d);
    load_en   = 1;
    load_addr = a;
    load_data = d;
    cyc("load");
  endtask

  task automatic sm(string tag, logic [9:0] p, logic dv,
                    logic [19:0] od, logic [2:0] ec, logic f);
    pc = p; d_valid = dv; out_data = od; err_code = ec; fin = f;
    cyc(tag);
    d_valid = 0;
    fin     = 0;
  endtask

  initial begin
    rst_n = 0; load_en = 0; load_addr = 0; load_data = 0;
    start = 0; pc = 0; d_valid = 0; out_data = 0; err_code = 0; fin = 0;
    model_reset();
    #12;
    compare("reset");
    @(negedge clk);
    rst_n = 1;

    load(10'd0, {3'b000, 10'd5, 3'd0, 20'd0});
    load(10'd1, {3'b001, 10'd0, 3'd0, 20'd9});
    load(10'd2, {3'b000, 10'd0, 3'd0, 20'd0});
    load(10'd3, {3'b000, 10'd1, 3'd3, 20'd0});
    load(10'd1023, {13'd0, 23'd2});

    start = 1;
    sm("t1s", 0, 0, 0, 0, 0);
    sm("t1a", 0, 1, 0, 0, 0);
    sm("t1b", 1, 1, 20'd9, 0, 0);
    chk("t1_nodone", 36'(done), 36'(0));
    sm("t1f", 1, 0, 0, 0, 1);
    chk("t1_hit2", 36'(hit_cnt), 36'(2));
    chk("t1_pass1", 36'(pass), 36'(1));

    start = 1;
    sm("t2s", 0, 0, 0, 0, 0);
    sm("t2a", 0, 1, 0, 0, 0);
    sm("t2b", 1, 1, 20'd8, 0, 0);
    sm("t2f", 1, 0, 0, 0, 1);
    chk("t2_err1", 36'(err_cnt), 36'(1));
    chk("t2_pass0", 36'(pass), 36'(0));

    load(10'd1, {3'b010, 10'd0, 3'd0, 20'd9});
    start = 1;
    sm("t3s", 0, 0, 0, 0, 0);
    sm("t3a", 1, 0, 0, 0, 0);
    sm("t3b", 2, 0, 0, 0, 0);
    sm("t3c", 2, 0, 0, 0, 0);
    chk("t3_err1", 36'(err_cnt), 36'(1));
    sm("t3f", 0, 0, 0, 0, 1);

    start = 1;
    sm("t4s", 0, 0, 0, 0, 0);
    sm("t4a", 1, 0, 0, 0, 0);
    sm("t4b", 3, 1, 0, 3'd3, 0);
    chk("t4_hit1", 36'(hit_cnt), 36'(1));
    chk("t4_err1", 36'(err_cnt), 36'(1));
    sm("t4f", 0, 0, 0, 0, 1);

    start = 1;
    sm("t5s", 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) sm("t5r", 2, 0, 0, 0, 0);
    chk("t5_done", 36'(done), 36'(1));
    chk("t5_to", 36'(timeout), 36'(1));
    start = 1;
    sm("t5c", 2, 0, 0, 0, 0);
    chk("t5_toclr", 36'(timeout), 36'(0));

    load(10'd1, {3'b001, 10'd0, 3'd0, 20'd9});
    start = 1;
    sm("t6s", 0, 0, 0, 0, 0);
    sm("t6a", 0, 1, 0, 0, 0);
    pc = 0;
    rst_n = 0;
    #2;
    model_reset();
    compare("t6rst");
    @(negedge clk);
    rst_n = 1;
    start = 1;
    sm("t6s2", 0, 0, 0, 0, 0);
    sm("t6a2", 0, 1, 0, 0, 0);
    sm("t6b2", 1, 1, 20'd9, 0, 0);
    sm("t6f2", 1, 0, 0, 0, 1);
    chk("t6_pass1", 36'(pass), 36'(1));

    for (int r = 0; r < 25; r++) begin
      int n;
      for (int a = 0; a < 12; a++)
        load(10'(a), 36'({$urandom, $urandom}));
      load(10'd1023, {13'd0, 23'($urandom_range(0, 6))});
      start = 1;
      sm("rs", 0, 0, 0, 0, 0);
      n = $urandom_range(4, 20);
      for (int k = 0; k < n; k++) begin
        logic [9:0]  p;
        logic [35:0] e;
        logic [19:0] od;
        logic [2:0]  ec;
        p  = 10'($urandom_range(0, 11));
        e  = mm[p];
        od = e[19:0];
        ec = e[22:20];
        if ($urandom_range(0, 2) == 0) od = 20'($urandom);
        if ($urandom_range(0, 3) == 0) ec = 3'($urandom);
        if ($urandom_range(0, 5) == 0) begin
          load_en   = 1;
          load_addr = 10'($urandom_range(0, 11));
          load_data = 36'({$urandom, $urandom});
        end
        sm("rnd", p, $urandom_range(0, 3) != 0, od, ec, k == n - 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
